// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, decoder state encoding and the
// classifier for bytes that never represent a key press.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_NONE  = 8'h00;

    // Prefix decoder states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } ps2_state_e;

    // Keyboard status/acknowledge bytes that are silently dropped in IDLE
    function automatic logic is_discard(input logic [7:0] code);
        logic hit;
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: hit = 1'b1;
            default:                                         hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_filter_if.sv
// Bundle between the make-code producer and the key FIFO: a push strobe
// with data on one side, the registered head/handshake/status on the other.
interface ps2_key_filter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push_valid;
    logic [7:0]    push_data;
    logic [7:0]    key_code;
    logic          key_valid;
    logic          key_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output push_valid, push_data, key_ready,
        input  key_code, key_valid, fifo_count, overflow
    );

    modport slave (
        input  push_valid, push_data, key_ready,
        output key_code, key_valid, fifo_count, overflow
    );

endinterface

// File: rtl/key_fifo.sv
// Make-code FIFO with a registered head. A push becomes visible the cycle
// after its edge (no bypass); a pop and a push may share an edge even when
// full. A push into a full FIFO with no pop is dropped and flagged sticky.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ps2_key_filter_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    count_after_pop_s;
    logic [WIDTH-1:0] key_code_q;
    logic [WIDTH-1:0] key_code_d;
    logic             key_valid_q;
    logic             key_valid_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             pop_s;
    logic             full_s;
    logic             push_ok_s;

    // Handshake decode, occupancy update and next head selection
    always_comb begin
        pop_s      = key_valid_q & bus.key_ready;
        full_s     = (count_q == CW'(DEPTH));
        push_ok_s  = bus.push_valid & (~full_s | pop_s);
        overflow_d = overflow_q | (bus.push_valid & full_s & ~pop_s);

        if (pop_s) begin
            rd_ptr_d          = rd_ptr_q + AW'(1);
            count_after_pop_s = count_q - CW'(1);
        end else begin
            rd_ptr_d          = rd_ptr_q;
            count_after_pop_s = count_q;
        end

        if (push_ok_s) begin
            count_d = count_after_pop_s + CW'(1);
        end else begin
            count_d = count_after_pop_s;
        end

        key_valid_d = (count_d != CW'(0));

        // When the FIFO drains, the head keeps showing the last code
        if (count_d == CW'(0)) begin
            key_code_d = key_code_q;
        end else if (push_ok_s && (count_after_pop_s == CW'(0))) begin
            key_code_d = bus.push_data;
        end else begin
            key_code_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array written at the write pointer on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= bus.push_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Pointers, count, registered head and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            key_code_q  <= {WIDTH{1'b0}};
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.key_code   = key_code_q;
    assign bus.key_valid  = key_valid_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: rtl/ps2_key_filter.sv
// PS/2 scan-code filter: strips break/extended sequences and status bytes,
// optionally suppresses typematic repeats of the held key, and queues the
// remaining make codes for a downstream consumer.
module ps2_key_filter
    import ps2_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int REPEAT_FILTER = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 ps2_received_data,
    input  logic                       ps2_received_data_strb,
    output logic [7:0]                 key_code,
    output logic                       key_valid,
    input  logic                       key_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    logic [1:0]  rst_sync_q;
    logic        rst_int_n;
    ps2_state_e  state_q;
    ps2_state_e  state_d;
    logic [7:0]  held_q;
    logic [7:0]  held_d;
    logic        push_s;

    ps2_key_filter_if #(.DEPTH(DEPTH)) fifo_if ();

    // Reset asserts immediately but releases two edges later, so the first
    // edge after release never pushes or pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Prefix decoder and repeat filter; state only moves on a strobe
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        push_s  = 1'b0;
        if (ps2_received_data_strb) begin
            case (state_q)
                ST_IDLE: begin
                    if (ps2_received_data == SC_BREAK) begin
                        state_d = ST_BREAK;
                    end else if (ps2_received_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (is_discard(ps2_received_data)) begin
                        state_d = ST_IDLE;
                    end else if ((REPEAT_FILTER != 0) && (ps2_received_data == held_q)) begin
                        state_d = ST_IDLE;
                    end else begin
                        push_s = 1'b1;
                        if (REPEAT_FILTER != 0) begin
                            held_d = ps2_received_data;
                        end else begin
                            held_d = held_q;
                        end
                    end
                end
                ST_BREAK: begin
                    state_d = ST_IDLE;
                    if (ps2_received_data == held_q) begin
                        held_d = SC_NONE;
                    end else begin
                        held_d = held_q;
                    end
                end
                ST_EXT: begin
                    if (ps2_received_data == SC_BREAK) begin
                        state_d = ST_EXT_BREAK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BREAK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Decoder state and currently held key
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_IDLE;
            held_q  <= SC_NONE;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    assign fifo_if.push_valid = push_s;
    assign fifo_if.push_data  = ps2_received_data;
    assign fifo_if.key_ready  = key_ready;

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_key_fifo (
        .clk   (clk),
        .rst_n (rst_int_n),
        .bus   (fifo_if.slave)
    );

    assign key_code   = fifo_if.key_code;
    assign key_valid  = fifo_if.key_valid;
    assign fifo_count = fifo_if.fifo_count;
    assign overflow   = fifo_if.overflow;

endmodule

// File: tb/tb_ps2_key_filter.sv
// Bench for ps2_key_filter: two instances (repeat filter on / off) share one
// stimulus stream; a list-based reference model is compared every cycle and
// directed sequences pin delivered streams against literal values.
module tb_ps2_key_filter;

    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       strb    = 1'b0;
    logic       rdy     = 1'b0;
    logic       started = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_key_filter_if #(.DEPTH(DEPTH)) if_rf1 ();
    ps2_key_filter_if #(.DEPTH(DEPTH)) if_rf0 ();

    assign if_rf1.push_data  = din;
    assign if_rf1.push_valid = strb;
    assign if_rf1.key_ready  = rdy;
    assign if_rf0.push_data  = din;
    assign if_rf0.push_valid = strb;
    assign if_rf0.key_ready  = rdy;

    ps2_key_filter #(.DEPTH(DEPTH), .REPEAT_FILTER(1)) dut_rf1 (
        .clk(clk), .rst_n(rst_n),
        .ps2_received_data(if_rf1.push_data), .ps2_received_data_strb(if_rf1.push_valid),
        .key_code(if_rf1.key_code), .key_valid(if_rf1.key_valid), .key_ready(if_rf1.key_ready),
        .fifo_count(if_rf1.fifo_count), .overflow(if_rf1.overflow)
    );

    ps2_key_filter #(.DEPTH(DEPTH), .REPEAT_FILTER(0)) dut_rf0 (
        .clk(clk), .rst_n(rst_n),
        .ps2_received_data(if_rf0.push_data), .ps2_received_data_strb(if_rf0.push_valid),
        .key_code(if_rf0.key_code), .key_valid(if_rf0.key_valid), .key_ready(if_rf0.key_ready),
        .fifo_count(if_rf0.fifo_count), .overflow(if_rf0.overflow)
    );

    // ---------------- reference model (index 0: filter on, 1: filter off)
    logic [7:0] mlist [2][DEPTH];
    int         msize [2] = '{0, 0};
    logic [7:0] mheld [2] = '{8'h00, 8'h00};
    logic [7:0] ecode [2] = '{8'h00, 8'h00};
    logic       eovf  [2] = '{1'b0, 1'b0};
    int         pend  [2] = '{0, 0};   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    int         blank = 2;
    logic [7:0] deliv [2][$];

    function automatic bit is_status(input logic [7:0] b);
        logic [7:0] lst [7];
        lst = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
        foreach (lst[k]) if (lst[k] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            msize[d] = 0; mheld[d] = 8'h00; ecode[d] = 8'h00; eovf[d] = 1'b0; pend[d] = 0;
        end
        blank = 2;
    endtask

    task automatic model_step(input int d);
        logic [7:0] b;
        bit rf, pop, make, push;
        b = din; rf = (d == 0); pop = (msize[d] > 0) && rdy; make = 0; push = 0;
        if (strb) begin
            if (pend[d] == 0) begin
                if (b == 8'hF0) pend[d] = 1;
                else if (b == 8'hE0) pend[d] = 2;
                else if (!is_status(b)) make = 1;
            end else if (pend[d] == 1) begin
                if (b == mheld[d]) mheld[d] = 8'h00;
                pend[d] = 0;
            end else if (pend[d] == 2) begin
                pend[d] = (b == 8'hF0) ? 3 : 0;
            end else begin
                pend[d] = 0;
            end
        end
        if (make && !(rf && b == mheld[d])) begin
            push = 1;
            if (rf) mheld[d] = b;
        end
        if (pop) begin
            for (int k = 0; k < DEPTH - 1; k++) mlist[d][k] = mlist[d][k+1];
            msize[d]--;
        end
        if (push) begin
            if (msize[d] == DEPTH) eovf[d] = 1'b1;
            else begin mlist[d][msize[d]] = b; msize[d]++; end
        end
        if (msize[d] > 0) ecode[d] = mlist[d][0];
    endtask

    // Model advances on the same edges as the DUTs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear();
        else if (blank > 0) blank--;
        else for (int d = 0; d < 2; d++) model_step(d);
    end

    // ---------------- checking
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic v, input logic [7:0] c,
                           input logic [2:0] n, input logic o);
        chk($sformatf("valid_%0d", d), {15'd0, v}, {15'd0, (msize[d] > 0)});
        chk($sformatf("code_%0d", d),  {8'd0, c},  {8'd0, ecode[d]});
        chk($sformatf("count_%0d", d), {13'd0, n}, 16'(msize[d]));
        chk($sformatf("ovf_%0d", d),   {15'd0, o}, {15'd0, eovf[d]});
    endtask

    // Per-cycle compare against the model plus capture of delivered codes
    always @(negedge clk) begin
        if (started) begin
            cmp_dut(0, if_rf1.key_valid, if_rf1.key_code, if_rf1.fifo_count, if_rf1.overflow);
            cmp_dut(1, if_rf0.key_valid, if_rf0.key_code, if_rf0.fifo_count, if_rf0.overflow);
            if (if_rf1.key_valid && rdy) deliv[0].push_back(if_rf1.key_code);
            if (if_rf0.key_valid && rdy) deliv[1].push_back(if_rf0.key_code);
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        din = b; strb = 1'b1;
        tick();
        strb = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic clear_deliv();
        deliv[0].delete();
        deliv[1].delete();
    endtask

    task automatic chk_stream(input string nm, input int d, input logic [7:0] exp [$]);
        chk({nm, "_len"}, 16'(deliv[d].size()), 16'(exp.size()));
        for (int k = 0; k < exp.size() && k < deliv[d].size(); k++)
            chk($sformatf("%s_%0d", nm, k), {8'd0, deliv[d][k]}, {8'd0, exp[k]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pool [12];
        pool = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'h00};

        repeat (2) tick();
        started = 1'b1;
        #4;
        chk("rst_valid", {15'd0, if_rf1.key_valid}, 16'd0);
        chk("rst_code",  {8'd0, if_rf1.key_code},   16'd0);
        chk("rst_count", {13'd0, if_rf1.fifo_count}, 16'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Make then break of one key: single delivery, visible next cycle
        rdy = 1'b1; clear_deliv();
        send(8'h1C);
        chk("lat_valid_rf1", {15'd0, if_rf1.key_valid}, 16'd1);
        chk("lat_valid_rf0", {15'd0, if_rf0.key_valid}, 16'd1);
        send(8'hF0); send(8'h1C);
        repeat (5) tick();
        chk_stream("mk_brk_rf1", 0, '{8'h1C});
        chk_stream("mk_brk_rf0", 1, '{8'h1C});

        // Typematic repeats
        clear_deliv();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        repeat (6) tick();
        chk_stream("rep_rf1", 0, '{8'h1C, 8'h1C});
        chk_stream("rep_rf0", 1, '{8'h1C, 8'h1C, 8'h1C, 8'h1C});
        send(8'hF0); send(8'h1C);
        repeat (2) tick();

        // Extended sequences and status bytes deliver nothing
        clear_deliv();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'hAA); send(8'hFA);
        repeat (3) tick();
        chk("ext_len_rf1", 16'(deliv[0].size()), 16'd0);
        chk("ext_count_rf1", {13'd0, if_rf1.fifo_count}, 16'd0);

        // Overflow with consumer stalled, then ordered drain
        rdy = 1'b0; clear_deliv();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        tick();
        chk("ovf_count_rf1", {13'd0, if_rf1.fifo_count}, 16'd4);
        chk("ovf_flag_rf1",  {15'd0, if_rf1.overflow},   16'd1);
        chk("ovf_flag_rf0",  {15'd0, if_rf0.overflow},   16'd1);
        rdy = 1'b1;
        repeat (8) tick();
        chk_stream("drain_rf1", 0, '{8'h1C, 8'h32, 8'h21, 8'h23});
        chk_stream("drain_rf0", 1, '{8'h1C, 8'h32, 8'h21, 8'h23});

        // Full FIFO with push and pop on the same edge
        do_reset();
        chk("post_rst_ovf", {15'd0, if_rf1.overflow}, 16'd0);
        rdy = 1'b0; clear_deliv();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        chk("full_count", {13'd0, if_rf1.fifo_count}, 16'd4);
        rdy = 1'b1;
        send(8'h2B);
        rdy = 1'b0;
        chk("pp_count", {13'd0, if_rf1.fifo_count}, 16'd4);
        chk("pp_ovf",   {15'd0, if_rf1.overflow},   16'd0);
        rdy = 1'b1;
        repeat (8) tick();
        chk_stream("pp_rf1", 0, '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B});

        // Reset after a break prefix discards it
        clear_deliv();
        send(8'hF0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_code",  {8'd0, if_rf1.key_code},    16'd0);
        chk("mid_rst_valid", {15'd0, if_rf1.key_valid},  16'd0);
        chk("mid_rst_count", {13'd0, if_rf1.fifo_count}, 16'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        send(8'h1C);
        repeat (4) tick();
        chk_stream("rst_pref_rf1", 0, '{8'h1C});
        chk_stream("rst_pref_rf0", 1, '{8'h1C});

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int lvl;
            lvl = ((i / 400) % 2 == 0) ? 25 : 75;
            rdy = ($urandom_range(0, 99) < lvl);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 99) < 45) begin
                send(pool[$urandom_range(0, 11)]);
            end else begin
                tick();
            end
        end
        rdy = 1'b1;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_filter.md
PS2_KEY_FILTER -- requirements
Module: ps2_key_filter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter REPEAT_FILTER, default 1; 1 = suppress typematic repeats, 0 = pass them.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_received_data  input  8  byte from PS/2 receiver.
REQ-006 SHALL have port ps2_received_data_strb  input  1  one-cycle pulse, byte valid.
REQ-007 SHALL have port key_code  output  8  make code at FIFO head.
REQ-008 SHALL have port key_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port key_ready  input  1  downstream (Morse encoder) accepts head.
REQ-010 SHALL have port fifo_count  output  $clog2(DEPTH)+1  entries held.
REQ-011 SHALL have port overflow  output  1  sticky, a make code was dropped.

Function
REQ-012 SHALL advance the decoder FSM only on cycles with ps2_received_data_strb=1.
REQ-013 FSM states SHALL be IDLE, BREAK, EXT, EXT_BREAK.
REQ-014 IDLE: 0xF0 -> BREAK; 0xE0 -> EXT; 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF discarded, stay IDLE; any other byte = make code, stay IDLE.
REQ-015 BREAK: any byte discarded -> IDLE; if it equals held_code, held_code SHALL clear to 0x00.
REQ-016 EXT: 0xF0 -> EXT_BREAK; any other byte discarded -> IDLE (extended keys not encoded).
REQ-017 EXT_BREAK: any byte discarded -> IDLE.
REQ-018 On a make code with REPEAT_FILTER=1: if equal to held_code, discard; else push and set held_code to it.
REQ-019 With REPEAT_FILTER=0, every make code SHALL be pushed; held_code unused.
REQ-020 Push SHALL occur on the clock edge ending the strobe cycle; key_valid SHALL rise the following cycle when FIFO was empty (latency 1, no bypass).
REQ-021 Pop SHALL occur on any edge where key_valid=1 and key_ready=1; key_code SHALL show the next entry the cycle after.
REQ-022 key_code and key_valid SHALL be register-driven and stable while key_valid=1 and key_ready=0.
REQ-023 Full and push without pop: make code dropped, overflow set to 1, FIFO unchanged.
REQ-024 Full and push with simultaneous pop: both SHALL occur, count unchanged, no overflow.
REQ-025 Empty and key_ready=1: no pop, count stays 0; key_code SHALL hold its last value.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.
REQ-027 overflow SHALL clear only on reset.

Reset
REQ-028 rst_n=0 SHALL asynchronously force FSM=IDLE, held_code=0x00, pointers=0, fifo_count=0, key_valid=0, key_code=0x00, overflow=0.
REQ-029 Reset asserted mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix; the next byte after release SHALL be decoded from IDLE.
REQ-030 Deassertion SHALL be used synchronised to clk; no push or pop on the first edge after release.

Structure
REQ-031 Scan-code constants (0xF0, 0xE0, discard list) and the FSM state enum SHALL live in shared package ps2_pkg.
REQ-032 FIFO storage, pointers and count SHALL be sub-module key_fifo (parameter DEPTH, WIDTH=8); prefix FSM and repeat filter stay in ps2_key_filter.

Verification
REQ-033 Strobes 0x1C, 0xF0, 0x1C, key_ready=1 -> exactly one 0x1C delivered; key_valid high 1 cycle after first strobe.
REQ-034 REPEAT_FILTER=1, strobes 0x1C x3, 0xF0, 0x1C, 0x1C -> 0x1C delivered twice; REPEAT_FILTER=0 -> four times.
REQ-035 Strobes 0xE0, 0x75, 0xE0, 0xF0, 0x75, 0xAA, 0xFA -> nothing delivered, fifo_count=0.
REQ-036 DEPTH=4, key_ready=0, make codes 0x1C, 0x32, 0x21, 0x23, 0x24 -> fifo_count=4, overflow=1; then key_ready=1 -> 0x1C, 0x32, 0x21, 0x23 in order.
REQ-037 FIFO full, strobe 0x2B on same cycle as pop -> count stays 4, overflow=0, 0x2B delivered last.
REQ-038 Strobe 0xF0, pulse rst_n low 1 cycle, strobe 0x1C -> 0x1C delivered, all outputs zero during reset.
